// File: rtl/uart_pkg.sv
// Shared UART constants and the receiver state encoding.
package uart_pkg;

  // Bit period in clk cycles: 115200 baud at 100 MHz, shared with the transmitter.
  localparam int unsigned CLKS_PER_BIT = 868;

  // 8N1 frame shape.
  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync2.sv
// Two-flop synchroniser for asynchronous single-bit inputs (serial lines, buttons).
//   clk : sampling clock
//   rst : asynchronous active-high reset, loads RST_VAL into both flops
//   d   : asynchronous input
//   q   : synchronised output, two clk cycles behind d
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // First flop may go metastable; second flop gives it a full cycle to settle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-bit validation at mid-bit, centre sampling of
// 8 LSB-first data bits, stop-bit check, one-cycle result strobes.
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   rxd       : raw serial line, asynchronous, idle high
//   rx_data   : last correctly framed byte, held until the next good frame
//   rx_valid  : one-cycle pulse when rx_data has just been updated
//   frame_err : one-cycle pulse when the stop bit was sampled low
//   rx_busy   : high whenever the receiver is not idle
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
  parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  import uart_pkg::*;

  localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_BIT - 1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  logic             rxd_s;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       rx_data_d;
  logic             rx_valid_d;
  logic             frame_err_d;

  // Line is idle high, so the synchroniser must come out of reset as 1.
  sync2 #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxd_s)
  );

  // State, counters, shift register and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      rx_busy   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      rx_data   <= rx_data_d;
      rx_valid  <= rx_valid_d;
      frame_err <= frame_err_d;
      // Registered from the next state so it tracks the state register exactly.
      rx_busy   <= (state_d != IDLE);
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    rx_data_d   = rx_data;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rxd_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end

      START: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Line must still be low at mid start bit, otherwise it was a glitch.
        if (cnt_q == HALF_END) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rxd_s ? IDLE : DATA;
        end
      end

      DATA: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == BIT_END) begin
          cnt_d     = '0;
          shreg_d   = {rxd_s, shreg_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == LAST_BIT) begin
            state_d = STOP;
          end
        end
      end

      STOP: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Leaving at mid stop bit lets an immediately following start edge be caught.
        if (cnt_q == BIT_END) begin
          cnt_d = '0;
          if (rxd_s) begin
            rx_data_d  = shreg_q;
            rx_valid_d = 1'b1;
            state_d    = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end
      end

      BREAK: begin
        // Hold off start detection until the line is released.
        if (rxd_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomised scoreboard bench for uart_rx.
module tb_uart_rx;

  localparam int     CPB  = 160;
  localparam int     HALF = CPB / 2;
  // Pin edge to strobe: 2 sync cycles, half bit, 9 bit periods, 1 output register.
  localparam longint LAT  = 2 + HALF + 9 * CPB + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;

  uart_rx #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    bit         err;
    bit         chk_time;
    longint     t;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] last_good = 8'h00;
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         prev_busy = 1'b0;

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h) at cycle %0d",
               name, act, act, req, req, cyc);
    end
  endtask

  // Drive one frame starting at the current negedge; leaves rxd at the stop level.
  task automatic send_frame(input logic [7:0] b, input logic stop_val, input int bclk);
    exp_t e;
    e.data     = b;
    e.err      = (stop_val == 1'b0);
    e.chk_time = (bclk == CPB);
    e.t        = cyc + LAT;
    exp_q.push_back(e);
    rxd = 1'b0;
    repeat (bclk) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (bclk) @(negedge clk);
    end
    rxd = stop_val;
    repeat (bclk) @(negedge clk);
  endtask

  // Monitor: every strobe must match the head of the expectation queue.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (rx_valid || frame_err)) begin
      check("valid_err_exclusive", longint'(rx_valid && frame_err), 0);
      check("output_expected", longint'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("frame_err_kind", longint'(frame_err), longint'(e.err));
        if (e.err) begin
          check("rx_data_held", longint'(rx_data), longint'(last_good));
        end else begin
          check("rx_data", longint'(rx_data), longint'(e.data));
          check("busy_low_at_valid", longint'(rx_busy), 0);
          check("busy_before_valid", longint'(prev_busy), 1);
          last_good = e.data;
        end
        if (e.chk_time) check("strobe_cycle", cyc, e.t);
      end
    end
    prev_busy = rx_busy;
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: actual timeout required completion at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    longint     g0;
    logic [7:0] b;
    int         gap;
    int         rate;
    logic       stp;
    int         guard;

    rst = 1'b1;
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rx_data", longint'(rx_data), 0);
    check("reset_rx_valid", longint'(rx_valid), 0);
    check("reset_frame_err", longint'(frame_err), 0);
    check("reset_rx_busy", longint'(rx_busy), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single frame, then two frames back-to-back with a one-bit stop.
    send_frame(8'h55, 1'b1, CPB);
    repeat (CPB) @(negedge clk);
    send_frame(8'hA3, 1'b1, CPB);
    send_frame(8'h0F, 1'b1, CPB);
    repeat (CPB) @(negedge clk);

    // Short low glitch: false start, busy for about half a bit, no strobe.
    g0 = cyc;
    rxd = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rxd = 1'b1;
    check("glitch_busy_high", longint'(rx_busy), 1);
    repeat (HALF) @(negedge clk);
    check("glitch_busy_low", longint'(rx_busy), 0);
    check("glitch_data_kept", longint'(rx_data), longint'(last_good));
    check("glitch_elapsed", longint'((cyc - g0) > longint'(HALF + 3)), 1);
    repeat (CPB) @(negedge clk);

    // Good byte, then a framing error with the line held low.
    send_frame(8'h3C, 1'b1, CPB);
    repeat (CPB) @(negedge clk);
    send_frame(8'h00, 1'b0, CPB);
    repeat (2 * CPB) @(negedge clk);
    check("break_busy_high", longint'(rx_busy), 1);
    check("break_data_kept", longint'(rx_data), 8'h3C);
    rxd = 1'b1;
    repeat (4) @(negedge clk);
    check("break_release_idle", longint'(rx_busy), 0);
    repeat (CPB) @(negedge clk);

    // Reset after bit 3 of 0x96, then a clean 0x96 frame.
    b = 8'h96;
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    rst = 1'b1;
    rxd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_rx_data", longint'(rx_data), 0);
      check("rst_rx_valid", longint'(rx_valid), 0);
      check("rst_frame_err", longint'(frame_err), 0);
      check("rst_rx_busy", longint'(rx_busy), 0);
    end
    rst = 1'b0;
    last_good = 8'h00;
    repeat (2 * CPB) @(negedge clk);
    send_frame(8'h96, 1'b1, CPB);
    repeat (CPB) @(negedge clk);

    // Transmitter at roughly -3% and +3% bit period.
    send_frame(8'hC9, 1'b1, 155);
    repeat (CPB) @(negedge clk);
    send_frame(8'hC9, 1'b1, 165);
    repeat (CPB) @(negedge clk);

    // Random bytes at nominal rate with random gaps, some with a bad stop bit.
    for (int i = 0; i < 6; i++) begin
      b   = 8'($urandom);
      gap = $urandom_range(0, CPB);
      stp = ($urandom_range(0, 3) != 0);
      send_frame(b, stp, CPB);
      if (!stp) begin
        repeat ($urandom_range(1, CPB)) @(negedge clk);
      end
      rxd = 1'b1;
      repeat (gap) @(negedge clk);
    end

    // Random bytes at random rates inside the tolerance band.
    for (int i = 0; i < 4; i++) begin
      b    = 8'($urandom);
      rate = $urandom_range(155, 165);
      send_frame(b, 1'b1, rate);
      repeat (CPB / 2) @(negedge clk);
    end

    guard = 0;
    while (exp_q.size() != 0 && guard < 4 * CPB) begin
      @(negedge clk);
      guard++;
    end
    check("all_frames_received", longint'(exp_q.size()), 0);
    repeat (2 * CPB) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
